// File: rtl/tx_ppe_egr_ingress_if.sv
// Beat bus between the egress channels, the ingress stage and the PPE pipeline.
// Valid/ready: a beat moves on a rising edge where valid and ready are both high;
// a source holding valid keeps its payload stable until that edge.
interface tx_ppe_egr_ingress_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 256
);
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH-1:0]          in_ready;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH-1:0]          in_sop;
    logic [NUM_CH-1:0]          in_eop;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic                       out_sop;
    logic                       out_eop;
    logic [$clog2(NUM_CH)-1:0]  out_ch;

    modport master (
        output in_valid, in_data, in_sop, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_ch
    );
    modport slave (
        input  in_valid, in_data, in_sop, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_ch
    );
endinterface

// File: rtl/tx_ppe_egr_ingress.sv
// TX PPE egress ingress: per-channel FIFOs, packet-boundary round-robin arbiter,
// registered output stream, framing checks and saturating per-channel packet counters.
module tx_ppe_egr_ingress #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                      cclk,
    input  logic                      reset_n,
    tx_ppe_egr_ingress_if.slave       bus,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [$clog2(NUM_CH)-1:0] cnt_rd_ch,
    output logic [CNT_W-1:0]          cnt_rd_data,
    input  logic                      cnt_clr,
    output logic [NUM_CH-1:0]         err_frame,
    input  logic                      err_clr,
    output logic                      o_dbg_state,
    output logic [$clog2(NUM_CH)-1:0] o_dbg_rr_ptr
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int EW   = DATA_W + 2;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [EW-1:0]     r_mem   [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     r_wptr  [NUM_CH];
    logic [PW-1:0]     r_rptr  [NUM_CH];
    logic [PW:0]       r_count [NUM_CH];
    logic [CNT_W-1:0]  r_pkt_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_wr_d, r_in_pkt, r_err;
    logic [NUM_CH-1:0] w_acc, w_wr, w_err_set, w_avail, w_pop_vec;
    logic [CH_W-1:0]   r_gnt, r_rr, w_gnt_nxt, w_rr_nxt, w_win, w_pop_ch;
    logic              r_gap, w_any, w_free, w_pop, w_cnt_inc;
    logic [EW-1:0]     w_head;
    logic              r_out_valid, r_out_sop, r_out_eop;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;
    logic [CNT_W-1:0]  r_cnt_rd;

    // A beat written at an edge is hidden for one cycle (r_wr_d), so it reaches the
    // arbiter one cycle after acceptance and the output one cycle after that.
    always_comb begin
        bus.in_ready = '0;
        w_acc        = '0;
        w_wr         = '0;
        w_err_set    = '0;
        w_avail      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            bus.in_ready[c] = (r_count[c] != FULL_CNT);
            w_acc[c]        = bus.in_valid[c] && bus.in_ready[c];
            w_wr[c]         = w_acc[c] && (bus.in_sop[c] || r_in_pkt[c]);
            w_err_set[c]    = w_acc[c] && (bus.in_sop[c] == r_in_pkt[c]);
            w_avail[c]      = (r_count[c] > (PW+1)'(r_wr_d[c]));
        end
    end

    always_ff @(posedge cclk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_wr[c]) begin
                r_mem[c][r_wptr[c]] <= {bus.in_sop[c] && !r_in_pkt[c], bus.in_eop[c],
                                        bus.in_data[c*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wptr[c]  <= '0;
                r_rptr[c]  <= '0;
                r_count[c] <= '0;
            end
            r_wr_d   <= '0;
            r_in_pkt <= '0;
            r_err    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_wr[c])      r_wptr[c] <= r_wptr[c] + 1'b1;
                if (w_pop_vec[c]) r_rptr[c] <= r_rptr[c] + 1'b1;
                r_count[c] <= r_count[c] + (PW+1)'(w_wr[c]) - (PW+1)'(w_pop_vec[c]);
                if (w_acc[c]) begin
                    if (bus.in_eop[c])      r_in_pkt[c] <= 1'b0;
                    else if (bus.in_sop[c]) r_in_pkt[c] <= 1'b1;
                end
            end
            r_wr_d <= w_wr;
            r_err  <= (r_err & ~{NUM_CH{err_clr}}) | w_err_set;
        end
    end

    always_comb begin
        int j;
        j     = 0;
        w_any = 1'b0;
        w_win = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(r_rr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (!w_any && ch_en[j] && w_avail[j]) begin
                w_any = 1'b1;
                w_win = CH_W'(j);
            end
        end
    end

    assign w_free   = !r_out_valid || bus.out_ready;
    assign w_pop_ch = (r_state == ST_IDLE) ? w_win : r_gnt;
    assign w_head   = r_mem[w_pop_ch][r_rptr[w_pop_ch]];

    // r_gap holds off arbitration for the cycle after an EOP pop: one dead cycle per packet.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr;
        case (r_state)
            ST_IDLE: begin
                if (!r_gap && w_free && w_any) begin
                    w_pop       = 1'b1;
                    w_gnt_nxt   = w_win;
                    w_rr_nxt    = (w_win == CH_W'(NUM_CH-1)) ? '0 : w_win + 1'b1;
                    w_state_nxt = w_head[DATA_W] ? ST_IDLE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_free && w_avail[r_gnt]) begin
                    w_pop = 1'b1;
                    if (w_head[DATA_W]) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pop_vec = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_pop_vec[c] = w_pop && (w_pop_ch == CH_W'(c));
        end
    end

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_rr        <= '0;
            r_gap       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_out_ch    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rr    <= w_rr_nxt;
            r_gap   <= w_pop && w_head[DATA_W];
            if (w_pop) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_head[DATA_W-1:0];
                r_out_sop   <= w_head[DATA_W+1];
                r_out_eop   <= w_head[DATA_W];
                r_out_ch    <= w_pop_ch;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign w_cnt_inc = r_out_valid && bus.out_ready && r_out_eop;

    always_ff @(posedge cclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) r_pkt_cnt[c] <= '0;
            r_cnt_rd <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_clr && (cnt_rd_ch == CH_W'(c))) begin
                    r_pkt_cnt[c] <= (w_cnt_inc && (r_out_ch == CH_W'(c))) ? CNT_W'(1) : '0;
                end else if (w_cnt_inc && (r_out_ch == CH_W'(c)) && (r_pkt_cnt[c] != '1)) begin
                    r_pkt_cnt[c] <= r_pkt_cnt[c] + 1'b1;
                end
            end
            r_cnt_rd <= (int'(cnt_rd_ch) < NUM_CH) ? r_pkt_cnt[cnt_rd_ch] : '0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sop   = r_out_sop;
    assign bus.out_eop   = r_out_eop;
    assign bus.out_ch    = r_out_ch;
    assign cnt_rd_data   = r_cnt_rd;
    assign err_frame     = r_err;
    assign o_dbg_state   = r_state;
    assign o_dbg_rr_ptr  = r_rr;
endmodule

// File: tb/tb_tx_ppe_egr_ingress.sv
// Directed bench for tx_ppe_egr_ingress: latency, round-robin, backpressure,
// framing errors, counter saturation/clear, reset flush and channel disable.
module tb_tx_ppe_egr_ingress;
    localparam int NUM_CH     = 4;
    localparam int DATA_W     = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 8;

    logic              cclk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NUM_CH-1:0] ch_en;
    logic [1:0]        cnt_rd_ch;
    logic [CNT_W-1:0]  cnt_rd_data;
    logic              cnt_clr;
    logic [NUM_CH-1:0] err_frame;
    logic              err_clr;
    logic              dbg_state;
    logic [1:0]        dbg_rr;

    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_d[$];
    logic              got_sop[$];
    logic              got_eop[$];
    logic [1:0]        got_ch[$];

    tx_ppe_egr_ingress_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    tx_ppe_egr_ingress #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
    ) dut (
        .cclk(cclk),
        .reset_n(reset_n),
        .bus(bus),
        .ch_en(ch_en),
        .cnt_rd_ch(cnt_rd_ch),
        .cnt_rd_data(cnt_rd_data),
        .cnt_clr(cnt_clr),
        .err_frame(err_frame),
        .err_clr(err_clr),
        .o_dbg_state(dbg_state),
        .o_dbg_rr_ptr(dbg_rr)
    );

    always #5 cclk = ~cclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid = '0;
        bus.in_sop   = '0;
        bus.in_eop   = '0;
        bus.in_data  = '0;
    endtask

    task automatic set_beat(input int ch, input logic [DATA_W-1:0] d, input logic s, input logic e);
        bus.in_valid[ch]                 = 1'b1;
        bus.in_data[ch*DATA_W +: DATA_W] = d;
        bus.in_sop[ch]                   = s;
        bus.in_eop[ch]                   = e;
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] d, input logic s, input logic e);
        logic acc;
        acc = 1'b0;
        set_beat(ch, d, s, e);
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = bus.in_ready[ch];
            step();
        end
        bus.in_valid[ch] = 1'b0;
        chk("push_accept", acc, 1);
    endtask

    task automatic collect(input int n, input int budget);
        got_d.delete();
        got_sop.delete();
        got_eop.delete();
        got_ch.delete();
        for (int k = 0; k < budget && got_d.size() < n; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_sop.push_back(bus.out_sop);
                got_eop.push_back(bus.out_eop);
                got_ch.push_back(bus.out_ch);
            end
            step();
        end
        chk("collect_count", got_d.size(), n);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        while (!bus.out_valid && k < budget) begin
            step();
            k++;
        end
        chk(tag, bus.out_valid, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive_idle();
        bus.out_ready = 1'b1;
        ch_en     = '1;
        cnt_clr   = 1'b0;
        err_clr   = 1'b0;
        cnt_rd_ch = '0;
        repeat (2) step();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", {bus.out_data, bus.out_sop, bus.out_eop, bus.out_ch}, 0);
        chk("rst_in_ready", bus.in_ready, 4'hF);
        chk("rst_cnt_rd", cnt_rd_data, 0);
        chk("rst_err", err_frame, 0);
        chk("rst_state_rr", {dbg_state, dbg_rr}, 0);
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        logic acc;
        logic seen;
        int   n;
        int   sops;

        // Single packet on ch 2: latency, framing, counter
        do_reset();
        cnt_rd_ch = 2'd2;
        set_beat(2, 16'h00A0, 1'b1, 1'b0);
        step();
        chk("lat_t0_valid", bus.out_valid, 0);
        set_beat(2, 16'h00A1, 1'b0, 1'b0);
        step();
        chk("lat_t1_valid", bus.out_valid, 0);
        set_beat(2, 16'h00A2, 1'b0, 1'b1);
        step();
        drive_idle();
        chk("lat_b0", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_ch, bus.out_data}, {1'b1, 1'b1, 1'b0, 2'd2, 16'h00A0});
        step();
        chk("lat_b1", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_ch, bus.out_data}, {1'b1, 1'b0, 1'b0, 2'd2, 16'h00A1});
        step();
        chk("lat_b2", {bus.out_valid, bus.out_sop, bus.out_eop, bus.out_ch, bus.out_data}, {1'b1, 1'b0, 1'b1, 2'd2, 16'h00A2});
        step();
        chk("lat_end_valid", bus.out_valid, 0);
        step();
        chk("lat_cnt2", cnt_rd_data, 1);

        // Round-robin across four loaded channels
        do_reset();
        ch_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < 2; b++) push(c, DATA_W'(16'h1000 * (c + 1) + b), b == 0, b == 1);
        end
        ch_en = '1;
        wait_valid("rr_start", 10);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < 2; b++) begin
                chk("rr_beat", {bus.out_valid, bus.out_ch, bus.out_sop, bus.out_eop, bus.out_data},
                    {1'b1, 2'(c), b == 0, b == 1, DATA_W'(16'h1000 * (c + 1) + b)});
                step();
            end
            if (c < NUM_CH - 1) begin
                chk("rr_bubble", bus.out_valid, 0);
                step();
            end
        end
        chk("rr_end_valid", bus.out_valid, 0);
        chk("rr_ptr_end", dbg_rr, 0);

        // Backpressure: 10 beats on ch 1 with the output stalled
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            set_beat(1, DATA_W'(16'h0100 + i), i == 0, 1'b0);
            chk("bp_ready_open", bus.in_ready[1], 1);
            step();
        end
        set_beat(1, 16'h0109, 1'b0, 1'b1);
        chk("bp_full", bus.in_ready[1], 0);
        chk("bp_stall_head", {bus.out_valid, bus.out_data}, {1'b1, 16'h0100});
        repeat (3) step();
        chk("bp_stall_hold", {bus.out_valid, bus.out_sop, bus.out_data}, {1'b1, 1'b1, 16'h0100});
        chk("bp_still_full", bus.in_ready[1], 0);
        bus.out_ready = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(DATA_W'(16'h0100 + i));
        got_d.delete();
        for (int k = 0; k < 60 && got_d.size() < 10; k++) begin
            acc = bus.in_valid[1] && bus.in_ready[1];
            if (bus.out_valid && bus.out_ready) got_d.push_back(bus.out_data);
            step();
            if (acc) bus.in_valid[1] = 1'b0;
        end
        chk("bp_count", got_d.size(), 10);
        n = 0;
        while (exp_q.size() > 0) begin
            chk("bp_order", got_d[n], exp_q.pop_front());
            n++;
        end

        // Framing errors on ch 3
        do_reset();
        push(3, 16'h0300, 1'b0, 1'b0);
        chk("fr_err_drop", err_frame, 4'b1000);
        push(3, 16'h0301, 1'b1, 1'b0);
        push(3, 16'h0302, 1'b1, 1'b0);
        push(3, 16'h0303, 1'b0, 1'b1);
        collect(3, 20);
        sops = 0;
        for (int i = 0; i < got_sop.size(); i++) if (got_sop[i]) sops++;
        chk("fr_sop_count", sops, 1);
        chk("fr_first", {got_d[0], got_sop[0], got_ch[0]}, {16'h0301, 1'b1, 2'd3});
        chk("fr_last", {got_d[1], got_d[2], got_eop[2]}, {16'h0302, 16'h0303, 1'b1});
        chk("fr_err_sticky", err_frame, 4'b1000);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("fr_err_clr", err_frame, 0);
        err_clr = 1'b1;
        push(0, 16'h0010, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk("fr_set_wins", err_frame, 4'b0001);

        // Counter saturation and clear on ch 0
        do_reset();
        cnt_rd_ch = 2'd0;
        n = 0;
        set_beat(0, 16'h0055, 1'b1, 1'b1);
        for (int k = 0; k < 3000 && n < 255; k++) begin
            acc = bus.in_ready[0];
            step();
            if (acc) n++;
            if (n == 255) bus.in_valid[0] = 1'b0;
        end
        bus.in_valid[0] = 1'b0;
        chk("cnt_pushed", n, 255);
        repeat (30) step();
        chk("cnt_at_max", cnt_rd_data, 8'hFF);
        push(0, 16'h0056, 1'b1, 1'b1);
        repeat (10) step();
        chk("cnt_saturate", cnt_rd_data, 8'hFF);
        push(0, 16'h0057, 1'b1, 1'b1);
        n = 0;
        while (!(bus.out_valid && bus.out_eop && bus.out_ch == 2'd0) && n < 10) begin
            step();
            n++;
        end
        chk("cnt_eop_seen", bus.out_valid && bus.out_eop, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("cnt_rd_old", cnt_rd_data, 8'hFF);
        step();
        chk("cnt_clr_inc", cnt_rd_data, 1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        step();
        chk("cnt_clr_only", cnt_rd_data, 0);

        // Reset mid-packet flushes everything
        do_reset();
        push(2, 16'h0200, 1'b0, 1'b0);
        push(1, 16'h0110, 1'b1, 1'b0);
        push(1, 16'h0111, 1'b0, 1'b0);
        push(1, 16'h0112, 1'b0, 1'b0);
        wait_valid("mid_valid", 10);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_ready", bus.in_ready, 4'hF);
        chk("mid_rst_err", err_frame, 0);
        chk("mid_rst_state", dbg_state, 0);
        step();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_flushed", seen, 0);

        // ch 1 disabled while it holds a packet
        ch_en = 4'b1101;
        push(1, 16'h0120, 1'b1, 1'b0);
        push(1, 16'h0121, 1'b0, 1'b1);
        push(0, 16'h0010, 1'b1, 1'b1);
        seen = 1'b0;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            if (bus.out_valid && bus.out_ch == 2'd1) seen = 1'b1;
            if (bus.out_valid && bus.out_ch == 2'd0) n++;
            step();
        end
        chk("dis_no_grant", seen, 0);
        chk("dis_ch0_beats", n, 1);
        ch_en = '1;
        collect(2, 20);
        chk("dis_resume", {got_ch[0], got_d[0], got_ch[1], got_d[1], got_eop[1]},
            {2'd1, 16'h0120, 2'd1, 16'h0121, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
